// File: rtl/i2s_tx_if.sv
// ----------------------------------------------------------------------------
// i2s_tx_if
// Sample hand-off between the sample-player stage and the I2S transmitter.
//   sample_i : signed 24-bit PCM sample (same format as the player's sound_o)
//   valid_i  : sample_i carries a sample this cycle
//   ready_o  : transmitter FIFO can accept; a transfer happens on a clk_i
//              rising edge with valid_i & ready_o
// master = sample producer, slave = i2s_tx.
// ----------------------------------------------------------------------------
interface i2s_tx_if;
   logic signed [23:0] sample_i;
   logic               valid_i;
   logic               ready_o;

   modport master (output sample_i, output valid_i, input ready_o);
   modport slave  (input sample_i, input valid_i, output ready_o);
endinterface

// File: rtl/i2s_tx.sv
// ----------------------------------------------------------------------------
// i2s_tx
// Mono-to-stereo I2S transmitter with a small sample FIFO.
// A frame is 64 bit-clocks (32 left, 32 right). Each half sends the held
// sample MSB first, delayed one bit after the word-select change, followed
// by zero padding. A new sample is taken from the FIFO once per frame; an
// empty FIFO at that point plays silence and raises a one-cycle underrun.
//
// Ports
//   clk_i      : system clock, all state on the rising edge
//   reset_i    : asynchronous active-low reset
//   smp        : sample hand-off (sample_i / valid_i / ready_o)
//   bclk_o     : I2S bit clock, half-period = clk_div_p clk_i cycles
//   lrclk_o    : I2S word select, 0 = left, 1 = right
//   sdata_o    : I2S serial data, MSB first
//   underrun_o : one-cycle pulse when a frame starts with the FIFO empty
//
// Parameters
//   clk_div_p    : clk_i cycles per bclk_o half-period (1..255)
//   fifo_depth_p : FIFO entries, power of 2 from 2 to 16
// ----------------------------------------------------------------------------
module i2s_tx #(
   parameter int unsigned clk_div_p    = 4,
   parameter int unsigned fifo_depth_p = 4
) (
   input  logic     clk_i,
   input  logic     reset_i,
   i2s_tx_if.slave  smp,
   output logic     bclk_o,
   output logic     lrclk_o,
   output logic     sdata_o,
   output logic     underrun_o
);

   localparam int unsigned      PTR_W    = $clog2(fifo_depth_p);
   localparam int unsigned      CNT_W    = $clog2(fifo_depth_p + 1);
   localparam logic [7:0]       DIV_LAST = 8'(clk_div_p - 1);
   localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(fifo_depth_p);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

   // Bit driven in half-slot s: slot 0 is the I2S one-bit delay, slots 1..24
   // carry bits 23..0, slots 25..31 are padding.
   function automatic logic slot_bit(input logic [23:0] word, input logic [4:0] s);
      logic [4:0] idx;
      if ((s >= 5'd1) && (s <= 5'd24)) begin
         idx      = 5'd24 - s;
         slot_bit = word[idx];
      end else begin
         idx      = 5'd0;
         slot_bit = 1'b0;
      end
   endfunction

   // divider / bit clock
   logic [7:0]       div_cnt_r;
   logic             bclk_r;
   // serializer
   logic [5:0]       slot_r;
   logic             lrclk_r;
   logic             sdata_r;
   logic             underrun_r;
   logic [23:0]      hold_r;
   // FIFO
   logic [23:0]      mem_r [fifo_depth_p];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             ready_r;

   logic             tick_s;
   logic             fall_s;
   logic             frame_s;
   logic             empty_s;
   logic             push_s;
   logic             pop_s;
   logic [5:0]       slot_nxt_s;
   logic [CNT_W-1:0] count_nxt_s;
   logic [23:0]      hold_nxt_s;
   logic             sdata_nxt_s;

   // Next-state decode for divider edges, frame boundary and FIFO occupancy
   always_comb begin
      tick_s     = (div_cnt_r == DIV_LAST);
      fall_s     = tick_s & bclk_r;
      // 63->0 slot transition: the frame boundary where a sample is taken
      frame_s    = fall_s & (slot_r == 6'd63);
      empty_s    = (count_r == CNT_ZERO);
      push_s     = smp.valid_i & ready_r;
      // No bypass: a sample pushed at the boundary cannot be popped there
      pop_s      = frame_s & ~empty_s;
      slot_nxt_s = slot_r + 6'd1;

      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase

      if (frame_s) begin
         if (empty_s) begin
            hold_nxt_s = 24'd0;
         end else begin
            hold_nxt_s = mem_r[rd_ptr_r];
         end
      end else begin
         hold_nxt_s = hold_r;
      end

      // Same word on both halves: only the low 5 slot bits select the bit
      sdata_nxt_s = slot_bit(hold_nxt_s, slot_nxt_s[4:0]);
   end

   // Bit-clock divider: toggle bclk every clk_div_p cycles, first rise
   // clk_div_p cycles after reset release
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         div_cnt_r <= 8'd0;
         bclk_r    <= 1'b0;
      end else if (tick_s) begin
         div_cnt_r <= 8'd0;
         bclk_r    <= ~bclk_r;
      end else begin
         div_cnt_r <= div_cnt_r + 8'd1;
      end
   end

   // Serializer: slot counter, word select and data move only on bclk falls
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         slot_r     <= 6'd63;
         lrclk_r    <= 1'b0;
         sdata_r    <= 1'b0;
         underrun_r <= 1'b0;
         hold_r     <= 24'd0;
      end else begin
         if (fall_s) begin
            slot_r  <= slot_nxt_s;
            lrclk_r <= slot_nxt_s[5];
            sdata_r <= sdata_nxt_s;
         end else begin
            slot_r  <= slot_r;
            lrclk_r <= lrclk_r;
            sdata_r <= sdata_r;
         end
         hold_r     <= hold_nxt_s;
         underrun_r <= frame_s & empty_s;
      end
   end

   // Sample FIFO: circular buffer with wrap-around pointers and occupancy
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < int'(fifo_depth_p); i++) begin
            mem_r[i] <= 24'd0;
         end
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
         ready_r  <= 1'b0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= smp.sample_i;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r        <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         count_r <= count_nxt_s;
         // Registered from the next count so it tracks count_r exactly and
         // stays low until the first edge after reset release
         ready_r <= (count_nxt_s < DEPTH);
      end
   end

   assign smp.ready_o = ready_r;
   assign bclk_o      = bclk_r;
   assign lrclk_o     = lrclk_r;
   assign sdata_o     = sdata_r;
   assign underrun_o  = underrun_r;

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

   logic clk_i   = 1'b0;
   logic reset_i = 1'b0;
   logic bclk_o, lrclk_o, sdata_o, underrun_o;

   i2s_tx_if smp ();

   i2s_tx #(.clk_div_p(4), .fifo_depth_p(4)) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .smp        (smp),
      .bclk_o     (bclk_o),
      .lrclk_o    (lrclk_o),
      .sdata_o    (sdata_o),
      .underrun_o (underrun_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [63:0] bits;
      logic [63:0] lr;
      logic        ur;
      int          pushes;
   } frame_t;

   localparam logic [63:0] LR_EXP = {32'hFFFF_FFFF, 32'h0000_0000};

   int errors = 0;
   int checks = 0;

   frame_t      frames_q [$];
   logic [23:0] exp_q    [$];
   int          acc_total = 0;
   int          pops_done = 0;

   // monitor state
   int     fall_cnt, cur_slot, frames_started, ur_cnt, last_ur_cyc, prev_ur_cyc, cyc;
   logic   prev_bclk;
   frame_t cur_f;

   // Monitor: counts bclk falls itself, rebuilds slot number and frames
   initial begin
      forever begin
         @(negedge clk_i);
         if (!reset_i) begin
            prev_bclk = 1'b0; fall_cnt = 0; cur_slot = -1; frames_started = 0;
            ur_cnt = 0; last_ur_cyc = 0; prev_ur_cyc = 0; cyc = 0;
         end else begin
            cyc++;
            if (prev_bclk && !bclk_o) begin
               cur_slot = fall_cnt % 64;
               cur_f.bits[cur_slot] = sdata_o;
               cur_f.lr[cur_slot]   = lrclk_o;
               if (cur_slot == 0) begin
                  cur_f.ur     = underrun_o;
                  cur_f.pushes = acc_total;
                  frames_started++;
               end
               if (cur_slot == 63) frames_q.push_back(cur_f);
               fall_cnt++;
            end
            if (underrun_o) begin
               ur_cnt++;
               prev_ur_cyc = last_ur_cyc;
               last_ur_cyc = cyc;
            end
            prev_bclk = bclk_o;
         end
      end
   end

   function automatic logic [63:0] frame_bits(input logic [23:0] x);
      logic [63:0] b = 64'd0;
      for (int s = 1; s <= 24; s++) begin
         b[s]      = x[24-s];
         b[s + 32] = x[24-s];
      end
      return b;
   endfunction

   // Scoreboard: a frame plays the oldest sample pushed before it started
   task automatic expect_next(input frame_t f, output logic [63:0] eb, output logic eur);
      if ((f.pushes > pops_done) && (exp_q.size() > 0)) begin
         eb  = frame_bits(exp_q.pop_front());
         eur = 1'b0;
         pops_done++;
      end else begin
         eb  = 64'd0;
         eur = 1'b1;
      end
   endtask

   task automatic get_frame(output frame_t f, output bit to);
      to = 1'b1;
      for (int n = 0; n < 1200; n++) begin
         if (frames_q.size() > 0) begin
            f  = frames_q.pop_front();
            to = 1'b0;
            break;
         end
         @(negedge clk_i);
      end
   endtask

   task automatic clear_model();
      frames_q.delete();
      exp_q.delete();
      acc_total = 0;
      pops_done = 0;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk_i);
      reset_i       = 1'b0;
      smp.valid_i   = 1'b0;
      repeat (n) @(negedge clk_i);
      clear_model();
      reset_i = 1'b1;
   endtask

   task automatic push_sample(input logic [23:0] x, output bit ok);
      ok = 1'b0;
      @(negedge clk_i);
      smp.sample_i = x;
      smp.valid_i  = 1'b1;
      for (int n = 0; n < 40; n++) begin
         if (smp.ready_o === 1'b1) begin
            @(posedge clk_i);
            acc_total++;
            exp_q.push_back(x);
            ok = 1'b1;
            break;
         end
         @(negedge clk_i);
      end
   endtask

   task automatic test_reset();
      reset_i     = 1'b0;
      smp.valid_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         checks++;
         if ({bclk_o, lrclk_o, sdata_o, underrun_o, smp.ready_o} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {bclk_o, lrclk_o, sdata_o, underrun_o, smp.ready_o});
         end
      end
      clear_model();
      reset_i = 1'b1;
      #1;
      checks++;
      if (smp.ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_release: got %b required 0", smp.ready_o);
      end
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk_i);
         #1;
         if (i == 1) begin
            checks++;
            if (smp.ready_o !== 1'b1) begin
               errors++;
               $display("FAIL reset_ready_rise: got %b required 1", smp.ready_o);
            end
         end
         checks++;
         if (bclk_o !== (i == 4)) begin
            errors++;
            $display("FAIL reset_first_bclk cycle %0d: got %b required %b", i, bclk_o, (i == 4));
         end
      end
   endtask

   task automatic test_single();
      frame_t f; bit to; bit ok; logic [63:0] eb; logic eur;
      do_reset(3);
      push_sample(24'hA5F00F, ok);
      @(negedge clk_i);
      smp.valid_i = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_push: accepted %b required 1", ok);
      end
      get_frame(f, to);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL single_frame_timeout: frame seen 0 required 1");
      end else begin
         expect_next(f, eb, eur);
         checks += 3;
         if (f.bits !== eb) begin
            errors++;
            $display("FAIL single_data: got %h required %h", f.bits, eb);
         end
         if (f.lr !== LR_EXP) begin
            errors++;
            $display("FAIL single_lrclk: got %h required %h", f.lr, LR_EXP);
         end
         if (f.ur !== eur) begin
            errors++;
            $display("FAIL single_underrun: got %b required %b", f.ur, eur);
         end
      end
   endtask

   task automatic test_full();
      logic [23:0] s [5] = '{24'h123456, 24'hFEDCBA, 24'h0F0F0F, 24'h7FFFFF, 24'hC30000};
      frame_t f; bit to; bit ok; logic [63:0] eb; logic eur;
      do_reset(3);
      for (int i = 0; i < 5; i++) begin
         push_sample(s[i], ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL full_push %0d: accepted %b required 1", i, ok);
         end
         if (i == 3) begin
            #1;
            checks++;
            if (smp.ready_o !== 1'b0) begin
               errors++;
               $display("FAIL full_ready: got %b required 0", smp.ready_o);
            end
         end
         if (i == 4) begin
            checks++;
            if (frames_started !== 1) begin
               errors++;
               $display("FAIL full_fifth_after_pop: frames started %0d required 1", frames_started);
            end
         end
      end
      @(negedge clk_i);
      smp.valid_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         get_frame(f, to);
         checks++;
         if (to) begin
            errors++;
            $display("FAIL full_frame_timeout %0d: frame seen 0 required 1", k);
         end else begin
            expect_next(f, eb, eur);
            checks += 3;
            if (f.bits !== eb) begin
               errors++;
               $display("FAIL full_data %0d: got %h required %h", k, f.bits, eb);
            end
            if (f.lr !== LR_EXP) begin
               errors++;
               $display("FAIL full_lrclk %0d: got %h required %h", k, f.lr, LR_EXP);
            end
            if (f.ur !== 1'b0) begin
               errors++;
               $display("FAIL full_underrun %0d: got %b required 0", k, f.ur);
            end
         end
      end
   endtask

   task automatic test_underrun();
      frame_t f; bit to; logic [63:0] eb; logic eur;
      do_reset(3);
      for (int k = 0; k < 3; k++) begin
         get_frame(f, to);
         checks++;
         if (to) begin
            errors++;
            $display("FAIL underrun_frame_timeout %0d: frame seen 0 required 1", k);
         end else begin
            expect_next(f, eb, eur);
            checks += 2;
            if (f.bits !== eb) begin
               errors++;
               $display("FAIL underrun_data %0d: got %h required %h", k, f.bits, eb);
            end
            if (f.ur !== eur) begin
               errors++;
               $display("FAIL underrun_pulse %0d: got %b required %b", k, f.ur, eur);
            end
         end
      end
      checks += 2;
      if (ur_cnt !== 3) begin
         errors++;
         $display("FAIL underrun_count: got %0d required 3", ur_cnt);
      end
      if ((last_ur_cyc - prev_ur_cyc) !== 512) begin
         errors++;
         $display("FAIL underrun_period: got %0d required 512", last_ur_cyc - prev_ur_cyc);
      end
   endtask

   task automatic test_boundary();
      logic [63:0] want [2] = '{64'h0000_0002_0000_0002, 64'h0100_0000_0100_0000};
      frame_t f; bit to; bit ok1; bit ok2; logic [63:0] eb; logic eur;
      do_reset(3);
      push_sample(24'h800000, ok1);
      push_sample(24'h000001, ok2);
      @(negedge clk_i);
      smp.valid_i = 1'b0;
      checks++;
      if (!(ok1 && ok2)) begin
         errors++;
         $display("FAIL boundary_push: accepted %b%b required 11", ok1, ok2);
      end
      for (int k = 0; k < 2; k++) begin
         get_frame(f, to);
         checks++;
         if (to) begin
            errors++;
            $display("FAIL boundary_frame_timeout %0d: frame seen 0 required 1", k);
         end else begin
            expect_next(f, eb, eur);
            checks += 2;
            if (f.bits !== want[k]) begin
               errors++;
               $display("FAIL boundary_data %0d: got %h required %h", k, f.bits, want[k]);
            end
            if (f.ur !== 1'b0) begin
               errors++;
               $display("FAIL boundary_underrun %0d: got %b required 0", k, f.ur);
            end
         end
      end
   endtask

   task automatic test_midreset();
      frame_t f; bit to; bit ok1; bit ok2; bit found; logic [63:0] eb; logic eur;
      do_reset(3);
      push_sample(24'hFFFFFF, ok1);
      push_sample(24'h5A5A5A, ok2);
      @(negedge clk_i);
      smp.valid_i = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 1200; n++) begin
         @(negedge clk_i);
         #1;
         if (cur_slot == 10) begin
            found = 1'b1;
            break;
         end
      end
      checks += 2;
      if (!found) begin
         errors++;
         $display("FAIL midreset_slot10: reached %b required 1", found);
      end
      if (sdata_o !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre_sdata: got %b required 1", sdata_o);
      end
      reset_i = 1'b0;
      #1;
      checks++;
      if ({bclk_o, lrclk_o, sdata_o, underrun_o, smp.ready_o} !== 5'b00000) begin
         errors++;
         $display("FAIL midreset_outputs: got %b required 00000",
                  {bclk_o, lrclk_o, sdata_o, underrun_o, smp.ready_o});
      end
      repeat (3) @(negedge clk_i);
      clear_model();
      reset_i = 1'b1;
      get_frame(f, to);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL midreset_frame_timeout: frame seen 0 required 1");
      end else begin
         expect_next(f, eb, eur);
         checks += 2;
         if (f.ur !== eur) begin
            errors++;
            $display("FAIL midreset_underrun: got %b required %b", f.ur, eur);
         end
         if (f.bits !== eb) begin
            errors++;
            $display("FAIL midreset_data: got %h required %h", f.bits, eb);
         end
      end
   endtask

   initial begin
      smp.valid_i  = 1'b0;
      smp.sample_i = 24'd0;
      test_reset();
      test_single();
      test_full();
      test_underrun();
      test_boundary();
      test_midreset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
